// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch unit.
//   - fetch_state_t : fetch FSM encodings (FETCH / WAIT / DROP)
//   - *_DEF         : default parameter values for address/data width,
//                     buffer depth and reset PC
//   - entry_w()     : width of one instruction buffer entry {data, pc}
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // may issue a request (subject to credit)
    ST_WAIT  = 2'd1,  // one request outstanding, response will be buffered
    ST_DROP  = 2'd2   // one request outstanding, response belongs to an old path
  } fetch_state_t;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 2;
  localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = '0;

  function automatic int unsigned entry_w(input int unsigned data_w,
                                          input int unsigned addr_w);
    return data_w + addr_w;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry FIFO holding fetched {data, pc} entries.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data (accepted when not full, or full with pop)
//   push_data  : entry to write
//   pop        : remove head entry (ignored while empty)
//   flush      : discard all entries; overrides push/pop of the same cycle
//   head_data  : current head entry (valid while !empty)
//   count      : number of stored entries
//   full/empty : occupancy flags
module fetch_fifo #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [W-1:0]             head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop && !empty;
  // A full buffer still takes a push when the head leaves in the same cycle.
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC and return-address registers, issues
// word-addressed instruction-memory reads (at most one outstanding) and
// buffers returned words for decode. A redirect reloads the PC, flushes the
// buffer and marks any in-flight response as stale.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   imem_req_valid/ready/addr   : instruction memory read request
//   imem_rsp_valid/data         : read response (no backpressure)
//   redirect_valid/pc           : taken branch/jump target from branch unit
//   ra_wr_en/ra_wr_data, ra_out : return-address register write / value
//   instr_valid/ready/data/pc   : buffered instruction stream to decode
//   dbg_state                   : current fetch FSM state
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// While valid is high and ready is low the payload (imem_req_addr,
// instr_data/instr_pc) is held, except that a redirect or reset may withdraw
// it. imem_rsp_valid is always accepted.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned         ADDR_W   = ADDR_W_DEF,
  parameter int unsigned         DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0]   RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int unsigned         DEPTH    = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [DATA_W-1:0]  imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               ra_wr_en,
  input  logic [ADDR_W-1:0]  ra_wr_data,
  output logic [ADDR_W-1:0]  ra_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [DATA_W-1:0]  instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  output fetch_state_t       dbg_state
);

  localparam int unsigned EW = entry_w(DATA_W, ADDR_W);

  fetch_state_t              state;
  logic [ADDR_W-1:0]         pc;
  logic [ADDR_W-1:0]         req_pc;     // address of the outstanding request
  logic                      outstanding;
  logic                      credit;
  logic                      req_fire;
  logic                      busy_after; // a request is still in flight after this edge
  logic                      push;
  logic [EW-1:0]             head;
  logic [$clog2(DEPTH):0]    count;
  logic                      full;
  logic                      empty;

  // Only one request may be in flight; a request is issued only if its
  // response is guaranteed a free buffer slot.
  assign outstanding = (state != ST_FETCH);
  assign credit      = !full && ((32'(count) + 32'(outstanding)) < DEPTH);

  assign imem_req_valid = !rst && (state == ST_FETCH) && credit;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response arriving in the redirect cycle retires the old request, so a
  // redirect only needs DROP if something is still in flight afterwards.
  assign busy_after = req_fire || (outstanding && !imem_rsp_valid);

  assign push = (state == ST_WAIT) && imem_rsp_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_FETCH;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      if (req_fire) begin
        pc     <= pc + ADDR_W'(1);
        req_pc <= pc;
      end
      if (redirect_valid) begin
        pc    <= redirect_pc;
        state <= busy_after ? ST_DROP : ST_FETCH;
      end else begin
        case (state)
          ST_FETCH: if (req_fire)       state <= ST_WAIT;
          ST_WAIT:  if (imem_rsp_valid) state <= ST_FETCH;
          ST_DROP:  if (imem_rsp_valid) state <= ST_FETCH;
          default:                      state <= ST_FETCH;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           ra_out <= '0;
    else if (ra_wr_en) ra_out <= ra_wr_data;
  end

  fetch_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({imem_rsp_data, req_pc}),
    .pop       (instr_ready),
    .flush     (redirect_valid),
    .head_data (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign instr_valid = !empty;
  assign instr_data  = head[EW-1:ADDR_W];
  assign instr_pc    = head[ADDR_W-1:0];
  assign dbg_state   = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. Memory returns ~addr as the word at
// addr after a programmable latency; the instruction stream is checked
// against an expected-PC queue.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid;
  logic [DW-1:0] imem_rsp_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          ra_wr_en;
  logic [AW-1:0] ra_wr_data;
  logic [AW-1:0] ra_out;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr_data;
  logic [AW-1:0] instr_pc;
  fetch_state_t  dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .RESET_PC (32'h0),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ra_wr_en       (ra_wr_en),
    .ra_wr_data     (ra_wr_data),
    .ra_out         (ra_out),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int unsigned   n_total = 0;
  int unsigned   n_pass  = 0;
  int unsigned   n_fail  = 0;
  logic [AW-1:0] exp_q[$];
  int unsigned   n_pops  = 0;
  logic [AW-1:0] last_pop_pc    = '0;
  logic [AW-1:0] last_fire_addr = '0;

  // memory model
  int unsigned   lat   = 1;
  logic          pend  = 1'b0;
  logic [AW-1:0] pend_addr = '0;
  int unsigned   pwait = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle: sample handshakes at the falling edge, then after the
  // rising edge drive the memory response.
  task automatic tick();
    logic          fire;
    logic [AW-1:0] faddr;
    logic [AW-1:0] e;
    @(negedge clk);
    fire  = imem_req_valid && imem_req_ready;
    faddr = imem_req_addr;
    if (instr_valid && instr_ready && !redirect_valid && !rst) begin
      n_pops++;
      last_pop_pc = instr_pc;
      chk("pop_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pop_pc", instr_pc, e);
        chk("pop_data", instr_data, ~e);
      end
    end
    @(posedge clk);
    #1;
    if (fire) begin
      last_fire_addr = faddr;
      pend      = 1'b1;
      pend_addr = faddr;
      pwait     = lat - 1;
    end
    imem_rsp_valid = 1'b0;
    if (pend) begin
      if (pwait == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ~pend_addr;
        pend           = 1'b0;
      end else begin
        pwait--;
      end
    end
    #1;
  endtask

  task automatic wait_state(input fetch_state_t st, input string tag);
    int n = 0;
    while (dbg_state != st && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(dbg_state), 32'(st));
  endtask

  task automatic new_path(input logic [AW-1:0] base);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(base + AW'(i));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int unsigned pops_before;
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; ra_wr_en = 1'b0; ra_wr_data = '0;
    instr_ready = 1'b0;
    repeat (3) tick();
    chk("rst_req_valid",   32'(imem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid),    32'd0);
    chk("rst_ra",          ra_out,              32'h0);
    chk("rst_state",       32'(dbg_state),      32'(ST_FETCH));

    // streaming: addresses 0,1,2... one instruction every two cycles
    new_path(32'h0);
    rst = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
    tick();
    chk("e1_state",     32'(dbg_state),      32'(ST_WAIT));
    chk("e1_req_valid", 32'(imem_req_valid), 32'd0);
    chk("e1_pc_inc",    imem_req_addr,       32'h1);
    chk("e1_fire_addr", last_fire_addr,      32'h0);
    tick();
    chk("e2_instr_valid", 32'(instr_valid),    32'd1);
    chk("e2_instr_pc",    instr_pc,            32'h0);
    chk("e2_instr_data",  instr_data,          32'hFFFF_FFFF);
    chk("e2_req_valid",   32'(imem_req_valid), 32'd1);
    chk("e2_req_addr",    imem_req_addr,       32'h1);
    repeat (6) tick();
    chk("stream_pops",      32'(n_pops),    32'd3);
    chk("stream_head_pc",   instr_pc,       32'h3);
    chk("stream_last_fire", last_fire_addr, 32'h3);

    // decode stalls for 10 cycles: buffer fills to DEPTH, fetch stops
    exp_q.delete();
    for (int i = 3; i < 12; i++) exp_q.push_back(AW'(i));
    instr_ready = 1'b0;
    repeat (10) tick();
    chk("stall_req_valid",   32'(imem_req_valid), 32'd0);
    chk("stall_instr_valid", 32'(instr_valid),    32'd1);
    chk("stall_head_pc",     instr_pc,            32'h3);
    chk("stall_head_data",   instr_data,          ~32'h3);
    chk("stall_last_fire",   last_fire_addr,      32'h4);
    chk("stall_state",       32'(dbg_state),      32'(ST_FETCH));
    instr_ready = 1'b1;
    tick();
    chk("release_head_pc",   instr_pc,            32'h4);
    chk("release_req_valid", 32'(imem_req_valid), 32'd1);
    chk("release_req_addr",  imem_req_addr,       32'h5);
    tick();
    chk("release_pops",      32'(n_pops),         32'd5);

    // return address register
    ra_wr_en = 1'b1; ra_wr_data = 32'h15;
    #1;
    chk("ra_before_edge", ra_out, 32'h0);
    tick();
    ra_wr_en = 1'b0;
    chk("ra_written", ra_out, 32'h15);

    // redirect while a request is outstanding (slow memory) -> DROP
    wait_state(ST_FETCH, "p3_sync_fetch");
    lat = 3;
    wait_state(ST_WAIT, "p3_sync_wait");
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    new_path(32'h40);
    tick();
    redirect_valid = 1'b0;
    chk("drop_state",       32'(dbg_state),      32'(ST_DROP));
    chk("drop_req_valid",   32'(imem_req_valid), 32'd0);
    chk("drop_instr_valid", 32'(instr_valid),    32'd0);
    chk("drop_pc",          imem_req_addr,       32'h40);
    tick();
    chk("drop_hold_state",  32'(dbg_state),      32'(ST_DROP));
    tick();
    chk("drop_done_state",  32'(dbg_state),      32'(ST_FETCH));
    chk("drop_req_valid2",  32'(imem_req_valid), 32'd1);
    chk("drop_req_addr",    imem_req_addr,       32'h40);
    lat = 1;
    repeat (3) tick();
    chk("p3_first_pc",      last_pop_pc,         32'h40);
    chk("ra_after_redir",   ra_out,              32'h15);

    // redirect with a full buffer and a pop in the same cycle
    instr_ready = 1'b0;
    repeat (8) tick();
    chk("full_state",       32'(dbg_state),      32'(ST_FETCH));
    chk("full_req_valid",   32'(imem_req_valid), 32'd0);
    chk("full_head_pc",     instr_pc,            32'h41);
    redirect_valid = 1'b1; redirect_pc = 32'h80; instr_ready = 1'b1;
    new_path(32'h80);
    tick();
    redirect_valid = 1'b0;
    chk("flush_instr_valid", 32'(instr_valid),    32'd0);
    chk("flush_state",       32'(dbg_state),      32'(ST_FETCH));
    chk("flush_req_valid",   32'(imem_req_valid), 32'd1);
    chk("flush_req_addr",    imem_req_addr,       32'h80);
    chk("flush_ra",          ra_out,              32'h15);

    // redirect in WAIT in the same cycle as the response, buffer non-empty
    repeat (4) tick();
    instr_ready = 1'b0;
    wait_state(ST_WAIT, "p4b_sync_wait");
    chk("p4b_buffered", 32'(instr_valid), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'hC0; instr_ready = 1'b1;
    new_path(32'hC0);
    tick();
    redirect_valid = 1'b0;
    chk("rsp_redir_state",    32'(dbg_state),      32'(ST_FETCH));
    chk("rsp_redir_ivalid",   32'(instr_valid),    32'd0);
    chk("rsp_redir_req_addr", imem_req_addr,       32'hC0);
    repeat (3) tick();
    chk("p4b_first_pc",       last_pop_pc,         32'hC0);

    // PC wrap-around
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    exp_q.delete();
    exp_q.push_back(32'hFFFF_FFFF);
    for (int i = 0; i < 4; i++) exp_q.push_back(AW'(i));
    tick();
    redirect_valid = 1'b0;
    chk("wrap_req_addr",  imem_req_addr,       32'hFFFF_FFFF);
    chk("wrap_req_valid", 32'(imem_req_valid), 32'd1);
    tick();
    chk("wrap_state",     32'(dbg_state),      32'(ST_WAIT));
    chk("wrap_next_pc",   imem_req_addr,       32'h0);
    tick();
    chk("wrap_instr_pc",  instr_pc,            32'hFFFF_FFFF);
    chk("wrap_instr_data", instr_data,         32'h0);
    tick();
    chk("wrap_fire_zero", last_fire_addr,      32'h0);
    chk("wrap_pop",       last_pop_pc,         32'hFFFF_FFFF);

    // reset while a request is outstanding: stale response must be ignored
    wait_state(ST_FETCH, "p7_sync_fetch");
    lat = 3;
    wait_state(ST_WAIT, "p7_sync_wait");
    rst = 1'b1;
    exp_q.delete();
    tick();
    chk("rstw_state",       32'(dbg_state),      32'(ST_FETCH));
    chk("rstw_req_valid",   32'(imem_req_valid), 32'd0);
    chk("rstw_instr_valid", 32'(instr_valid),    32'd0);
    tick();
    chk("rstw_ra",          ra_out,              32'h0);
    rst = 1'b0; lat = 1;
    for (int i = 0; i < 4; i++) exp_q.push_back(AW'(i));
    #1;
    chk("rstw_req_valid2",  32'(imem_req_valid), 32'd1);
    chk("rstw_req_addr",    imem_req_addr,       32'h0);
    pops_before = n_pops;
    tick();
    chk("rstw_fire_state",  32'(dbg_state),      32'(ST_WAIT));
    repeat (2) tick();
    chk("rstw_pops",        32'(n_pops - pops_before), 32'd1);
    chk("rstw_pop_pc",      last_pop_pc,         32'h0);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
